fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle/pipelined core. It owns the fetch PC and drives the address of the combinational-read instruction memory. It buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. It handles start-up, back-pressure, and branch/jump redirects with queue flush.

Parameters:
AddressWidth, 10, byte-address width of the instruction memory; PC width.
ResetPc, 0, byte address of the first fetch after reset; must be a multiple of 4.
QueueDepth, 2, number of instruction FIFO entries; range 2..8.

Ports:
clk_i  input  1  core clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
fetch_en_i  input  1  starts fetching from IDLE; level-sensitive.
imem_addr_o  output  AddressWidth  byte address to the instruction memory; always 4-byte aligned.
imem_data_i  input  32  instruction word returned combinationally for imem_addr_o.
redirect_i  input  1  single-cycle request to change the fetch stream (branch/jump taken).
redirect_pc_i  input  AddressWidth  redirect target byte address.
instr_valid_o  output  1  FIFO head holds a valid instruction.
instr_ready_i  input  1  decode accepts the head this cycle.
instr_o  output  32  instruction word at the FIFO head.
instr_pc_o  output  AddressWidth  PC of instr_o.
misalign_o  output  1  one-cycle pulse: the accepted redirect target had bits [1:0] != 0.

Behaviour:
- The clock is clk_i. Reset is rst_i: one clock, synchronous, active-high.
- Reset (rst_i=1 at the edge):
  - state=IDLE, fetch_pc=ResetPc, FIFO count=0, read/write pointers=0.
  - instr_valid_o=0, misalign_o=0, instr_o=0, instr_pc_o=0.
  - Reset overrides every other input, including mid-stream and mid-redirect.
- imem_addr_o = fetch_pc at all times (combinational), including in IDLE.
- FSM, two states:
  - IDLE: no enqueue. Go to RUN when fetch_en_i=1.
  - RUN: fetch as below. Go to IDLE when fetch_en_i=0. The FIFO is kept and still drains to decode; fetch_pc holds.
- Handshake:
  - deq = instr_valid_o & instr_ready_i.
  - instr_valid_o = (count != 0).
  - instr_o and instr_pc_o come from the head entry. They are undefined but stable when count=0.
  - Once valid is asserted, head contents must not change until deq, redirect or reset.
- Enqueue in RUN with no redirect:
  - enq = (count < QueueDepth) | deq. A full FIFO with a simultaneous deq still accepts.
  - On enq, write {imem_data_i, fetch_pc} at the tail, then fetch_pc <= fetch_pc + 4.
  - The increment wraps modulo 2^AddressWidth; no error is raised on wrap.
  - count <= count + enq - deq.
- Latency:
  - The first edge in RUN enqueues mem[ResetPc]; instr_valid_o rises the cycle after.
  - Sustained throughput is 1 instruction/cycle with instr_ready_i held at 1.
- Redirect (redirect_i=1 in RUN or IDLE):
  - Highest priority after reset.
  - Flush: count<=0, pointers<=0. No enqueue this cycle.
  - fetch_pc <= {redirect_pc_i[AW-1:2], 2'b00}.
  - A deq in the same cycle is counted as consumed by decode; the entry is still flushed.
  - misalign_o=1 on the next cycle if redirect_pc_i[1:0] != 0, else 0.
  - The cycle after a redirect enqueues the target (if in RUN); valid rises one cycle later. The redirect bubble is 2 cycles.
  - Back-to-back redirects: the last one wins; each one flushes.
- Wrong-path guarantee: no instruction from the pre-redirect stream is ever presented with valid after the redirect edge.

Test Plan:
- Reset then start: hold rst_i 2 cycles, then fetch_en_i=1, ready=1, memory mem[k]=0x100+k.
  -> valid rises on the 2nd edge after start; pairs are (0x100,pc 0), (0x101,4), (0x102,8), one per cycle.
- Back-pressure: ready=0 for 5 cycles while running.
  -> count saturates at QueueDepth=2; imem_addr_o stalls at 8; head stays (0x100,0).
  -> Release ready: the order is preserved with no duplicates or drops.
- Full + simultaneous deq/enq: FIFO full, ready=1 for one cycle.
  -> Exactly one entry leaves and one enters; count stays 2; fetch_pc advances by 4.
- Redirect: redirect_i=1 with redirect_pc_i=0x040 while 2 entries are queued.
  -> Next cycle valid=0; the cycle after, head=(mem[16],0x040).
  -> No old entries appear; misalign_o stays 0.
- Misaligned redirect and wrap: redirect_pc_i=0x3FE.
  -> misalign_o pulses 1 cycle; fetches come from 0x3FC, then 0x000 (wrap), with AddressWidth=10.
- Mid-stream reset and IDLE: assert rst_i while the FIFO is full and a redirect is pending.
  -> Next cycle valid=0, fetch_pc=ResetPc.
  -> With fetch_en_i=0 after reset, no enqueue occurs for 10 cycles.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, queues {word, pc} pairs in a small FIFO
// and hands them to decode over valid/ready; redirects flush the queue and retarget the PC.
module fetch_ctrl #(
  parameter int AddressWidth = 10,
  parameter int ResetPc      = 0,
  parameter int QueueDepth   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fetch_en_i,
  output logic [AddressWidth-1:0] imem_addr_o,
  input  logic [31:0]             imem_data_i,
  input  logic                    redirect_i,
  input  logic [AddressWidth-1:0] redirect_pc_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [31:0]             instr_o,
  output logic [AddressWidth-1:0] instr_pc_o,
  output logic                    misalign_o
);

  localparam int CW = $clog2(QueueDepth + 1);
  localparam int PW = $clog2(QueueDepth);
  localparam logic [CW-1:0] DepthC  = CW'(QueueDepth);
  localparam logic [PW-1:0] LastPtr = PW'(QueueDepth - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic                    misalign_q, misalign_d;
  logic [31:0]             data_q [QueueDepth];
  logic [31:0]             data_d [QueueDepth];
  logic [AddressWidth-1:0] pc_q   [QueueDepth];
  logic [AddressWidth-1:0] pc_d   [QueueDepth];

  logic enq, deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == LastPtr) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_q[rd_ptr_q];
  assign instr_pc_o    = pc_q[rd_ptr_q];
  assign misalign_o    = misalign_q;

  assign deq = instr_valid_o & instr_ready_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq = (state_q == RUN) & ~redirect_i & ((count_q < DepthC) | deq);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    misalign_d = 1'b0;
    data_d     = data_q;
    pc_d       = pc_q;

    case (state_q)
      IDLE:    if (fetch_en_i)  state_d = RUN;
      RUN:     if (!fetch_en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      // Flush drops everything queued, including an entry consumed this cycle.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc_i[AddressWidth-1:2], 2'b00};
      misalign_d = |redirect_pc_i[1:0];
    end else begin
      if (enq) begin
        data_d[wr_ptr_q] = imem_data_i;
        pc_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d         = next_ptr(wr_ptr_q);
        fetch_pc_d       = fetch_pc_q + AddressWidth'(4);
      end
      if (deq) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= AddressWidth'(ResetPc);
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < QueueDepth; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      misalign_q <= misalign_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

endmodule
